bitplane_packer: RTL and testbench
==================================

BITPLANE_PACKER -- requirements
Module: bitplane_packer

Interface
REQ-001 Parameter NUM_INPUTS, default 64, sets pixels per frame and the bit-plane width; SHALL be a multiple of 4.
REQ-002 Parameter PIXEL_BITS, default 8, sets bits per pixel and bit-planes per frame.
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 soft_reset_pulse  input  1  one-cycle abort of the current frame.
REQ-006 pix_wvalid  input  1  pixel word valid.
REQ-007 pix_wready  output  1  packer can accept a pixel word.
REQ-008 pix_wdata  input  32  four 8-bit pixels; byte k holds pixel 4*word_idx+k.
REQ-009 fifo_wdata  output  NUM_INPUTS  current bit-plane; bit i = bit plane_idx of pixel i.
REQ-010 fifo_push  output  1  write strobe to the input FIFO.
REQ-011 fifo_full  input  1  input FIFO full.
REQ-012 busy  output  1  high while a frame is partially loaded or being emitted.
REQ-013 frame_done_pulse  output  1  one-cycle pulse after a frame's last plane is pushed.
REQ-014 frames_packed  output  8  count of fully emitted frames.
REQ-015 plane_idx  output  clog2(PIXEL_BITS)  bit-plane currently offered.

Function
REQ-016 The FSM SHALL have two states: ST_LOAD and ST_EMIT.
REQ-017 pix_wready SHALL equal (state==ST_LOAD); a word is accepted on the cycle pix_wvalid && pix_wready.
REQ-018 Each accepted word SHALL be stored into frame buffer slots 4*word_idx..4*word_idx+3, after which word_idx increments.
REQ-019 Acceptance of word NUM_INPUTS/4-1 SHALL reset word_idx to 0, set plane_idx to PIXEL_BITS-1 and move to ST_EMIT on the next cycle.
REQ-020 fifo_push SHALL be combinational: (state==ST_EMIT) && !fifo_full; fifo_wdata SHALL be combinational from the buffer and plane_idx.
REQ-021 Planes SHALL be emitted MSB first: PIXEL_BITS-1 down to 0, one per push, with no repeats or skips.
REQ-022 While fifo_full=1 in ST_EMIT: no push, plane_idx holds, fifo_wdata stable.
REQ-023 On a push with plane_idx==0: next state ST_LOAD, frame_done_pulse=1 next cycle, frames_packed+1 (wraps 255->0).
REQ-024 On a push with plane_idx>0: plane_idx decrements and state remains ST_EMIT.
REQ-025 Latency: first push eligible the cycle after the last word is accepted; with no backpressure a frame takes NUM_INPUTS/4 + PIXEL_BITS cycles.
REQ-026 busy SHALL be high in ST_EMIT, and in ST_LOAD when word_idx != 0.
REQ-027 soft_reset_pulse SHALL take priority over all activity: state to ST_LOAD, word_idx 0, plane_idx PIXEL_BITS-1, no push and no word acceptance that cycle; frames_packed and buffer contents are retained.
REQ-028 A soft reset mid-emit SHALL produce no frame_done_pulse, and the partial frame SHALL NOT be resumed.

Reset
REQ-029 With rst=1 at a clock edge: state ST_LOAD, word_idx 0, plane_idx PIXEL_BITS-1, frame buffer all 0, frames_packed 0, frame_done_pulse 0, busy 0.
REQ-030 Resulting outputs: fifo_push 0, and pix_wready 1 from the first cycle after reset deasserts.
REQ-031 rst SHALL override soft_reset_pulse and all other inputs.

Verification
REQ-032 All 64 pixels = 0x80, fifo_full=0 -> 8 consecutive pushes: plane 7 = all ones, planes 6..0 = 0; frame_done_pulse once; frames_packed=1.
REQ-033 Pixel i = i (i=0..63) -> push for plane b has bit i = bit b of i (plane 0 = 0xAAAA_AAAA_AAAA_AAAA); planes 7 and 6 = 0.
REQ-034 fifo_full=1 for 3 cycles after the 2nd push -> no push for those cycles, plane_idx=5 and fifo_wdata stable; total still 8 pushes, frame takes 27 cycles.
REQ-035 soft_reset_pulse after the 3rd push -> no further pushes, no frame_done_pulse, pix_wready=1 next cycle, frames_packed unchanged; the next full frame emits all 8 planes.
REQ-036 pix_wvalid held 1 across ST_EMIT -> no words accepted until ST_LOAD; the word presented then is stored as word 0.
REQ-037 256 back-to-back frames -> frames_packed wraps to 0; rst asserted mid-load -> busy=0 and word_idx=0 the next cycle.

Source files
------------

// File: rtl/bitplane_packer_if.sv
// Pixel-word input and bit-plane FIFO output handshakes of the bit-plane packer.
// The packer takes the slave side; the pixel source / FIFO model takes the master side.
interface bitplane_packer_if #(
    parameter int NUM_INPUTS = 64
);
    logic                  pix_wvalid;
    logic                  pix_wready;
    logic [31:0]           pix_wdata;
    logic [NUM_INPUTS-1:0] fifo_wdata;
    logic                  fifo_push;
    logic                  fifo_full;

    modport slave (
        input  pix_wvalid, pix_wdata, fifo_full,
        output pix_wready, fifo_wdata, fifo_push
    );

    modport master (
        output pix_wvalid, pix_wdata, fifo_full,
        input  pix_wready, fifo_wdata, fifo_push
    );
endinterface

// File: rtl/bitplane_packer.sv
// Loads a frame of pixels four per word, then emits it one bit-plane per FIFO push, MSB plane first.
//   state   | meaning
//   ST_LOAD | accepting pixel words into the frame buffer
//   ST_EMIT | offering bit-plane plane_idx to the FIFO
module bitplane_packer #(
    parameter int  NUM_INPUTS = 64,
    parameter int  PIXEL_BITS = 8,
    localparam int PLANE_W    = (PIXEL_BITS > 1) ? $clog2(PIXEL_BITS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               soft_reset_pulse,
    bitplane_packer_if.slave   bus,
    output logic               busy,
    output logic               frame_done_pulse,
    output logic [7:0]         frames_packed,
    output logic [PLANE_W-1:0] plane_idx
);
    localparam int NUM_WORDS = NUM_INPUTS / 4;
    localparam int WORD_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int PIX_W     = WORD_W + 2;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    state_t                state;
    logic [WORD_W-1:0]     word_idx;
    logic [PIXEL_BITS-1:0] pix_buf [NUM_INPUTS];

    // A soft reset suppresses the handshakes in its own cycle so nothing appears to transfer.
    assign bus.pix_wready = (state == ST_LOAD) && !soft_reset_pulse;
    assign bus.fifo_push  = (state == ST_EMIT) && !bus.fifo_full && !soft_reset_pulse;
    assign busy           = (state == ST_EMIT) || (word_idx != '0);

    always_comb begin
        bus.fifo_wdata = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            bus.fifo_wdata[i] = pix_buf[i][plane_idx];
        end
    end

    always_ff @(posedge clk) begin
        frame_done_pulse <= 1'b0;
        if (rst) begin
            state         <= ST_LOAD;
            word_idx      <= '0;
            plane_idx     <= PLANE_W'(PIXEL_BITS - 1);
            frames_packed <= '0;
            for (int i = 0; i < NUM_INPUTS; i++) begin
                pix_buf[i] <= '0;
            end
        end else if (soft_reset_pulse) begin
            state     <= ST_LOAD;
            word_idx  <= '0;
            plane_idx <= PLANE_W'(PIXEL_BITS - 1);
        end else begin
            case (state)
                ST_LOAD: begin
                    if (bus.pix_wvalid) begin
                        for (int k = 0; k < 4; k++) begin
                            pix_buf[{word_idx, 2'(k)}] <= bus.pix_wdata[8*k +: PIXEL_BITS];
                        end
                        if (word_idx == WORD_W'(NUM_WORDS - 1)) begin
                            word_idx  <= '0;
                            plane_idx <= PLANE_W'(PIXEL_BITS - 1);
                            state     <= ST_EMIT;
                        end else begin
                            word_idx <= word_idx + 1'b1;
                        end
                    end
                end
                ST_EMIT: begin
                    if (!bus.fifo_full) begin
                        if (plane_idx == '0) begin
                            state            <= ST_LOAD;
                            plane_idx        <= PLANE_W'(PIXEL_BITS - 1);
                            frame_done_pulse <= 1'b1;
                            frames_packed    <= frames_packed + 1'b1;
                        end else begin
                            plane_idx <= plane_idx - 1'b1;
                        end
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

    logic unused_ok;
    assign unused_ok = ^{bus.pix_wdata, PIX_W[0]};
endmodule

// File: tb/tb_bitplane_packer.sv
// Directed bench for bitplane_packer: frame patterns, backpressure, soft reset, held valid, wrap, reset.
module tb_bitplane_packer;
    logic       clk = 1'b0;
    logic       rst;
    logic       soft_reset_pulse;
    logic       busy;
    logic       frame_done_pulse;
    logic [7:0] frames_packed;
    logic [2:0] plane_idx;

    bitplane_packer_if #(.NUM_INPUTS(64)) bus ();

    bitplane_packer #(.NUM_INPUTS(64), .PIXEL_BITS(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .soft_reset_pulse (soft_reset_pulse),
        .bus              (bus),
        .busy             (busy),
        .frame_done_pulse (frame_done_pulse),
        .frames_packed    (frames_packed),
        .plane_idx        (plane_idx)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [7:0]  pix [64];
    logic [63:0] cap [8];
    int          n_push, n_cyc, n_done;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] exp_plane(input int b);
        logic [63:0] r;
        for (int i = 0; i < 64; i++) r[i] = pix[i][b];
        return r;
    endfunction

    task automatic load_frame(input int start);
        for (int w = start; w < 16; w++) begin
            @(negedge clk);
            bus.pix_wvalid = 1'b1;
            bus.pix_wdata  = {pix[4*w+3], pix[4*w+2], pix[4*w+1], pix[4*w]};
            #1;
            chk("load_wready", 64'(bus.pix_wready), 64'(1));
            @(posedge clk);
        end
    endtask

    // Runs 14 cycles from the first emit cycle; stall/soft-reset positions are counted in pushes.
    task automatic emit_frame(input int stall_after, input int stall_len, input int sr_after,
                              input bit hold);
        int  exp_b = 7;
        int  stalls = 0;
        bit  sr_done = 0, sr_prev = 0, got = 0;
        n_push = 0; n_cyc = 0; n_done = 0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            bus.pix_wvalid   = hold && !got;
            bus.pix_wdata    = 32'h1122_3344;
            bus.fifo_full    = (n_push == stall_after) && (stalls < stall_len);
            soft_reset_pulse = (n_push == sr_after) && !sr_done;
            #1;
            if (frame_done_pulse) n_done++;
            if (sr_prev) begin
                chk("sr_wready_next", 64'(bus.pix_wready), 64'(1));
                chk("sr_busy_next", 64'(busy), 64'(0));
                sr_prev = 0;
            end
            if (soft_reset_pulse) begin
                chk("sr_no_push", 64'(bus.fifo_push), 64'(0));
                sr_done = 1; sr_prev = 1;
            end else if (bus.fifo_full) begin
                stalls++;
                chk("stall_no_push", 64'(bus.fifo_push), 64'(0));
                chk("stall_plane", 64'(plane_idx), 64'(exp_b));
                chk("stall_data", bus.fifo_wdata, exp_plane(exp_b));
            end else if (bus.fifo_push) begin
                chk("push_plane", 64'(plane_idx), 64'(exp_b));
                chk("push_data", bus.fifo_wdata, exp_plane(exp_b));
                chk("emit_busy", 64'(busy), 64'(1));
                if (hold) chk("hold_no_accept", 64'(bus.pix_wready), 64'(0));
                if (exp_b >= 0) cap[exp_b & 7] = bus.fifo_wdata;
                n_push++; exp_b--; n_cyc = c + 1;
            end
            if (hold && bus.pix_wready && bus.pix_wvalid) got = 1;
        end
        @(negedge clk);
        bus.pix_wvalid = 1'b0; bus.fifo_full = 1'b0; soft_reset_pulse = 1'b0;
    endtask

    initial begin
        rst = 1'b1; soft_reset_pulse = 1'b0;
        bus.pix_wvalid = 1'b0; bus.pix_wdata = '0; bus.fifo_full = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_push", 64'(bus.fifo_push), 64'(0));
        chk("rst_frames", 64'(frames_packed), 64'(0));
        chk("rst_done", 64'(frame_done_pulse), 64'(0));
        chk("rst_plane", 64'(plane_idx), 64'(7));
        rst = 1'b0;
        @(negedge clk);
        chk("wready_after_rst", 64'(bus.pix_wready), 64'(1));

        // all pixels 0x80
        for (int i = 0; i < 64; i++) pix[i] = 8'h80;
        load_frame(0);
        emit_frame(-1, 0, -1, 0);
        chk("p80_pushes", 64'(n_push), 64'(8));
        chk("p80_cycles", 64'(16 + n_cyc), 64'(24));
        chk("p80_done", 64'(n_done), 64'(1));
        chk("p80_frames", 64'(frames_packed), 64'(1));
        chk("p80_plane7", cap[7], 64'hFFFF_FFFF_FFFF_FFFF);
        chk("p80_plane0", cap[0], 64'h0);

        // pixel i = i
        for (int i = 0; i < 64; i++) pix[i] = 8'(i);
        load_frame(0);
        emit_frame(-1, 0, -1, 0);
        chk("ramp_pushes", 64'(n_push), 64'(8));
        chk("ramp_plane0", cap[0], 64'hAAAA_AAAA_AAAA_AAAA);
        chk("ramp_plane5", cap[5], 64'hFFFF_FFFF_0000_0000);
        chk("ramp_plane6", cap[6], 64'h0);
        chk("ramp_plane7", cap[7], 64'h0);
        chk("ramp_frames", 64'(frames_packed), 64'(2));

        // backpressure after the 2nd push for 3 cycles
        for (int i = 0; i < 64; i++) pix[i] = 8'(8'h5A ^ (i * 3));
        load_frame(0);
        emit_frame(2, 3, -1, 0);
        chk("stall_pushes", 64'(n_push), 64'(8));
        chk("stall_cycles", 64'(16 + n_cyc), 64'(27));
        chk("stall_frames", 64'(frames_packed), 64'(3));

        // soft reset after the 3rd push, then a clean frame
        load_frame(0);
        emit_frame(-1, 0, 3, 0);
        chk("sr_pushes", 64'(n_push), 64'(3));
        chk("sr_done", 64'(n_done), 64'(0));
        chk("sr_frames", 64'(frames_packed), 64'(3));
        for (int i = 0; i < 64; i++) pix[i] = 8'(255 - i);
        load_frame(0);
        emit_frame(-1, 0, -1, 0);
        chk("post_sr_pushes", 64'(n_push), 64'(8));
        chk("post_sr_frames", 64'(frames_packed), 64'(4));

        // valid held through emit: first word taken in LOAD becomes word 0
        for (int i = 0; i < 64; i++) pix[i] = 8'(i * 7 + 1);
        load_frame(0);
        emit_frame(-1, 0, -1, 1);
        chk("hold_pushes", 64'(n_push), 64'(8));
        chk("hold_busy_word0", 64'(busy), 64'(1));
        pix[0] = 8'h44; pix[1] = 8'h33; pix[2] = 8'h22; pix[3] = 8'h11;
        load_frame(1);
        emit_frame(-1, 0, -1, 0);
        chk("hold_word0_pushes", 64'(n_push), 64'(8));
        chk("hold_frames", 64'(frames_packed), 64'(6));

        // back-to-back frames until the counter wraps (6 + 250 = 256)
        n_done = 0;
        @(negedge clk);
        bus.pix_wvalid = 1'b1; bus.pix_wdata = 32'hC3A5_0F81;
        for (int c = 0; c < 250 * 24; c++) begin
            @(negedge clk);
            if (frame_done_pulse) n_done++;
        end
        bus.pix_wvalid = 1'b0;
        chk("wrap_done_count", 64'(n_done), 64'(250));
        chk("wrap_frames", 64'(frames_packed), 64'(0));
        chk("wrap_idle", 64'(busy), 64'(0));

        // rst mid-load, together with a soft reset
        for (int i = 0; i < 64; i++) pix[i] = 8'(i ^ 8'h3C);
        for (int w = 0; w < 5; w++) begin
            @(negedge clk);
            bus.pix_wvalid = 1'b1;
            bus.pix_wdata  = {pix[4*w+3], pix[4*w+2], pix[4*w+1], pix[4*w]};
        end
        @(negedge clk);
        bus.pix_wvalid = 1'b0;
        chk("midload_busy", 64'(busy), 64'(1));
        rst = 1'b1; soft_reset_pulse = 1'b1; bus.pix_wvalid = 1'b1;
        @(negedge clk);
        chk("rst_mid_busy", 64'(busy), 64'(0));
        chk("rst_mid_push", 64'(bus.fifo_push), 64'(0));
        chk("rst_mid_done", 64'(frame_done_pulse), 64'(0));
        rst = 1'b0; soft_reset_pulse = 1'b0; bus.pix_wvalid = 1'b0;
        #1;
        chk("rst_mid_wready", 64'(bus.pix_wready), 64'(1));
        load_frame(0);
        emit_frame(-1, 0, -1, 0);
        chk("post_rst_pushes", 64'(n_push), 64'(8));
        chk("post_rst_frames", 64'(frames_packed), 64'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
